mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the pipelined LEGv8 datapath. Consumes the execute stage's results (ALU result, store data, zero flag, branch target) and resolves the branch. For LDUR/STUR it runs a request/acknowledge transaction against a variable-latency data memory, stalling the pipeline until the access completes or times out. Results are presented to writeback with a one-cycle valid pulse.

## Interface
Parameters:
- N, 64, datapath width
- TIMEOUT, 15, maximum dm_req cycles without dm_ack before abort (≥1)

Ports:
- clk  in  1  clock; one clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents an instruction
- Branch_M  in  1  CBZ-type branch
- MemRead_M  in  1  load
- MemWrite_M  in  1  store
- aluResult_E  in  N  ALU result / memory address
- writeData_E  in  N  store data
- zero_E  in  1  ALU zero flag
- PCBranch_E  in  N  branch target
- stall  out  1  pipeline freeze request
- dm_req  out  1  data memory request
- dm_we  out  1  1 = write, 0 = read
- dm_addr  out  N  memory address
- dm_wdata  out  N  store data
- dm_ack  in  1  memory completion
- dm_rdata  in  N  load data, valid with dm_ack
- out_valid  out  1  one-cycle result pulse to writeback
- aluResult_M  out  N  registered ALU result
- readData_M  out  N  load data (0 for non-loads/errors)
- PCSrc  out  1  take branch
- PCBranch_M  out  N  registered branch target
- misaligned  out  1  access with aluResult_E[2:0] ≠ 0; pulses with out_valid
- bus_error  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: if in_valid, capture aluResult_E, writeData_E, PCBranch_E, Branch_M&zero_E, control bits.
  - memop = MemRead_M | MemWrite_M. Both set: treated as store.
  - memop and aluResult_E[2:0]==0 → ACCESS; counter cleared.
  - otherwise stay IDLE; next cycle out_valid=1; misaligned=1 if memop (no memory access).
- ACCESS: dm_req=1; dm_addr, dm_we, dm_wdata held stable from capture. stall=1.
  - dm_ack sampled high → capture dm_rdata if read (0 if write); next cycle out_valid=1; → IDLE.
  - no ack: counter increments; on TIMEOUT-th request cycle without ack → abort: bus_error set, readData_M=0, next cycle out_valid=1; → IDLE. Ack in that same cycle wins (normal completion).
- stall = (state==ACCESS). Upstream holds in_valid and fields while stall=1; inputs ignored outside IDLE.
- PCSrc = captured Branch_M&zero_E; asserted only in the out_valid cycle; PCBranch_M valid then.
- dm_ack in IDLE ignored. dm_req is 0 outside ACCESS.
- bus_error sticky until reset.

## Timing
- Reset: state IDLE; stall, dm_req, dm_we, out_valid, PCSrc, misaligned, bus_error = 0; all N-bit outputs = 0; counter = 0.
- Reset mid-ACCESS: dm_req low the cycle after reset sampled; transaction abandoned; no out_valid.
- Non-memory/misaligned: acceptance at edge t → out_valid at cycle t+1, one cycle.
- Memory: acceptance at edge t → dm_req and stall high from t+1; ack sampled at edge t+k (k≥1) → dm_req/stall low and out_valid high in cycle t+k+1; total latency k+1. Earliest ack is in the first dm_req cycle.
- Timeout: dm_req high exactly TIMEOUT cycles, then out_valid with bus_error=1.
- New instruction accepted in the same cycle out_valid is high (back-to-back, IDLE).
- out_valid, PCSrc, misaligned are single-cycle pulses; aluResult_M, readData_M, PCBranch_M hold until next capture.

## Test plan
- ALU op: in_valid, aluResult_E=0x40, no memop → next cycle out_valid=1, aluResult_M=0x40, readData_M=0, stall never high.
- Load, ack after 3 cycles, addr 0x10, dm_rdata=0xDEADBEEFCAFEF00D → dm_req/stall high 3 cycles, dm_we=0, out_valid next cycle with readData_M=0xDEADBEEFCAFEF00D.
- Store, addr 0x18, writeData_E=0x1234, ack in first req cycle → dm_we=1, dm_wdata=0x1234, one req cycle, out_valid next cycle, readData_M=0.
- Branch: Branch_M=1, zero_E=1, PCBranch_E=0x100 → PCSrc=1 for one cycle, PCBranch_M=0x100; repeat zero_E=0 → PCSrc=0.
- Misaligned load addr 0x13 → no dm_req, out_valid=1 with misaligned=1, readData_M=0.
- TIMEOUT=4, load with no ack → dm_req exactly 4 cycles, then out_valid, bus_error=1 sticky; reset asserted mid-access on a second load → dm_req drops next cycle, no out_valid, bus_error=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage -- memory stage of the pipelined LEGv8 datapath.
//
// Takes the execute stage's results, resolves CBZ-type branches and runs
// LDUR/STUR as a req/ack transaction against a variable-latency data memory.
// The pipeline is frozen while an access is in flight. Every accepted
// instruction produces one out_valid pulse, except one abandoned by reset.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   in_valid           execute stage presents an instruction (sampled in IDLE)
//   Branch_M, MemRead_M, MemWrite_M   control bits
//   aluResult_E        ALU result / memory address
//   writeData_E        store data
//   zero_E             ALU zero flag
//   PCBranch_E         branch target
//   stall              pipeline freeze request (high while accessing)
//   dm_req/dm_we/dm_addr/dm_wdata     data memory request side
//   dm_ack/dm_rdata    data memory completion side
//   out_valid          one-cycle result pulse to writeback
//   aluResult_M, readData_M, PCBranch_M   registered results
//   PCSrc              take branch, pulses with out_valid
//   misaligned         memop with addr[2:0] != 0, pulses with out_valid
//   bus_error          sticky memory timeout flag
module mem_stage #(
    parameter int N       = 64,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         Branch_M,
    input  logic         MemRead_M,
    input  logic         MemWrite_M,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic         zero_E,
    input  logic [N-1:0] PCBranch_E,
    output logic         stall,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ack,
    input  logic [N-1:0] dm_rdata,
    output logic         out_valid,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] readData_M,
    output logic         PCSrc,
    output logic [N-1:0] PCBranch_M,
    output logic         misaligned,
    output logic         bus_error
);

    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    // Counter only needs to reach TIMEOUT-1: the abort fires on that value.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  alu_q, alu_d;      // doubles as the held memory address
    logic [N-1:0]  wdata_q, wdata_d;
    logic [N-1:0]  pcb_q, pcb_d;
    logic [N-1:0]  rdata_q, rdata_d;
    logic          we_q, we_d;
    logic          br_q, br_d;        // captured Branch_M & zero_E
    logic          ov_q, ov_d;
    logic          pcsrc_q, pcsrc_d;
    logic          mis_q, mis_d;
    logic          berr_q, berr_d;

    logic memop, aligned;
    assign memop   = MemRead_M | MemWrite_M;
    assign aligned = (aluResult_E[2:0] == 3'b000);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        alu_d   = alu_q;
        wdata_d = wdata_q;
        pcb_d   = pcb_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        br_d    = br_q;
        berr_d  = berr_q;
        ov_d    = 1'b0;
        pcsrc_d = 1'b0;
        mis_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    alu_d   = aluResult_E;
                    wdata_d = writeData_E;
                    pcb_d   = PCBranch_E;
                    // Read+write together is treated as a store.
                    we_d    = MemWrite_M;
                    br_d    = Branch_M & zero_E;
                    rdata_d = '0;
                    if (memop && aligned) begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                    end else begin
                        ov_d    = 1'b1;
                        pcsrc_d = Branch_M & zero_E;
                        mis_d   = memop;
                    end
                end
            end
            ACCESS: begin
                // Ack beats timeout when both land in the same cycle.
                if (dm_ack) begin
                    rdata_d = we_q ? '0 : dm_rdata;
                    state_d = IDLE;
                    ov_d    = 1'b1;
                    pcsrc_d = br_q;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    berr_d  = 1'b1;
                    state_d = IDLE;
                    ov_d    = 1'b1;
                    pcsrc_d = br_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            alu_q   <= '0;
            wdata_q <= '0;
            pcb_q   <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            br_q    <= 1'b0;
            ov_q    <= 1'b0;
            pcsrc_q <= 1'b0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            pcb_q   <= pcb_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            br_q    <= br_d;
            ov_q    <= ov_d;
            pcsrc_q <= pcsrc_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    assign stall       = (state_q == ACCESS);
    assign dm_req      = (state_q == ACCESS);
    assign dm_we       = we_q;
    assign dm_addr     = alu_q;
    assign dm_wdata    = wdata_q;
    assign out_valid   = ov_q;
    assign aluResult_M = alu_q;
    assign readData_M  = rdata_q;
    assign PCSrc       = pcsrc_q;
    assign PCBranch_M  = pcb_q;
    assign misaligned  = mis_q;
    assign bus_error   = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int N = 64;

    logic         clk, reset, in_valid, Branch_M, MemRead_M, MemWrite_M, zero_E;
    logic [N-1:0] aluResult_E, writeData_E, PCBranch_E, dm_rdata;
    logic         dm_ack;
    logic         stall, dm_req, dm_we, out_valid, PCSrc, misaligned, bus_error;
    logic [N-1:0] dm_addr, dm_wdata, aluResult_M, readData_M, PCBranch_M;

    mem_stage #(.N(N), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .Branch_M(Branch_M), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
        .aluResult_E(aluResult_E), .writeData_E(writeData_E), .zero_E(zero_E),
        .PCBranch_E(PCBranch_E), .stall(stall), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .out_valid(out_valid), .aluResult_M(aluResult_M), .readData_M(readData_M),
        .PCSrc(PCSrc), .PCBranch_M(PCBranch_M), .misaligned(misaligned),
        .bus_error(bus_error)
    );

    typedef struct packed {
        logic [N-1:0] alu;
        logic [N-1:0] rdata;
        logic [N-1:0] pcb;
        logic         pcsrc;
        logic         mis;
        logic         berr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int ack_lat = 0;             // ack in this req cycle (1-based); 0 = never
    logic [N-1:0] mem_rdata = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_lat request cycles.
    initial begin
        int req_cnt;
        req_cnt  = 0;
        dm_ack   = 1'b0;
        dm_rdata = '0;
        forever begin
            @(negedge clk);
            if (dm_req && !reset) begin
                req_cnt++;
                dm_ack   = (ack_lat != 0) && (req_cnt == ack_lat);
                dm_rdata = dm_ack ? mem_rdata : '0;
            end else begin
                req_cnt  = 0;
                dm_ack   = 1'b0;
                dm_rdata = '0;
            end
        end
    end

    // Monitor: pops the scoreboard on every result pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("aluResult_M", aluResult_M, e.alu);
                    chk("readData_M", readData_M, e.rdata);
                    chk("PCBranch_M", PCBranch_M, e.pcb);
                    chk("PCSrc", PCSrc, e.pcsrc);
                    chk("misaligned", misaligned, e.mis);
                    chk("bus_error", bus_error, e.berr);
                end
            end
        end
    end

    task automatic issue(input logic br, input logic rd, input logic wr, input logic zero,
                         input logic [N-1:0] alu, input logic [N-1:0] wd, input logic [N-1:0] pcb,
                         input int lat, input logic [N-1:0] rdata,
                         input logic [N-1:0] exp_rdata, input logic exp_pcsrc,
                         input logic exp_mis, input logic exp_berr, input int exp_req);
        exp_t e;
        int reqs, stalls;
        logic done;
        @(negedge clk);
        Branch_M = br; MemRead_M = rd; MemWrite_M = wr; zero_E = zero;
        aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb;
        ack_lat = lat; mem_rdata = rdata;
        in_valid = 1'b1;
        e.alu = alu; e.rdata = exp_rdata; e.pcb = pcb;
        e.pcsrc = exp_pcsrc; e.mis = exp_mis; e.berr = exp_berr;
        q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        reqs = 0; stalls = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (dm_req) begin
                reqs++;
                if (reqs == 1) begin
                    chk("dm_addr", dm_addr, alu);
                    chk("dm_we", dm_we, wr);
                    if (wr) chk("dm_wdata", dm_wdata, wd);
                end
            end
            if (out_valid) done = 1'b1;
        end
        chk("complete", done, 1'b1);
        chk("req_cycles", reqs, exp_req);
        chk("stall_cycles", stalls, exp_req);
        @(negedge clk);
        chk("pulse_out_valid", out_valid, 1'b0);
        chk("pulse_PCSrc", PCSrc, 1'b0);
        chk("pulse_misaligned", misaligned, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0;
        Branch_M = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0; zero_E = 1'b0;
        aluResult_E = '0; writeData_E = '0; PCBranch_E = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_stall", stall, 1'b0);
        chk("rst_dm_req", dm_req, 1'b0);
        chk("rst_dm_we", dm_we, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_PCSrc", PCSrc, 1'b0);
        chk("rst_misaligned", misaligned, 1'b0);
        chk("rst_bus_error", bus_error, 1'b0);
        chk("rst_aluResult_M", aluResult_M, '0);
        chk("rst_readData_M", readData_M, '0);
        chk("rst_PCBranch_M", PCBranch_M, '0);
        chk("rst_dm_addr", dm_addr, '0);
        chk("rst_dm_wdata", dm_wdata, '0);

        //     br  rd  wr  z   alu     wdata   pcb     lat rdata                  exp_rdata              pcs mis berr req
        issue(0,  0,  0,  0, 64'h40, 64'h0,   64'h0,  0, 64'h0,                 64'h0,                 0,  0,  0,   0);
        issue(0,  1,  0,  0, 64'h10, 64'h0,   64'h0,  3, 64'hDEADBEEFCAFEF00D,  64'hDEADBEEFCAFEF00D,  0,  0,  0,   3);
        issue(0,  0,  1,  0, 64'h18, 64'h1234,64'h0,  1, 64'h5555,              64'h0,                 0,  0,  0,   1);
        issue(1,  0,  0,  1, 64'h0,  64'h0,   64'h100,0, 64'h0,                 64'h0,                 1,  0,  0,   0);
        issue(1,  0,  0,  0, 64'h8,  64'h0,   64'h100,0, 64'h0,                 64'h0,                 0,  0,  0,   0);
        issue(0,  1,  0,  0, 64'h13, 64'h0,   64'h0,  1, 64'h77,                64'h0,                 0,  1,  0,   0);
        issue(0,  1,  1,  0, 64'h20, 64'hABCD,64'h0,  2, 64'h99,                64'h0,                 0,  0,  0,   2);
        issue(0,  1,  0,  0, 64'h28, 64'h0,   64'h0,  0, 64'h0,                 64'h0,                 0,  0,  1,   4);
        // bus_error stays set on later instructions
        issue(0,  0,  0,  0, 64'h50, 64'h0,   64'h0,  0, 64'h0,                 64'h0,                 0,  0,  1,   0);

        // Reset in the middle of a second load that never gets acked.
        @(negedge clk);
        MemRead_M = 1'b1; MemWrite_M = 1'b0; Branch_M = 1'b0;
        aluResult_E = 64'h30; ack_lat = 0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; MemRead_M = 1'b0;
        @(negedge clk);
        chk("mid_dm_req_before", dm_req, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_dm_req_after", dm_req, 1'b0);
        chk("mid_stall_after", stall, 1'b0);
        chk("mid_out_valid", out_valid, 1'b0);
        chk("mid_bus_error", bus_error, 1'b0);
        reset = 1'b0;
        issue(0,  0,  0,  0, 64'h60, 64'h0,   64'h0,  0, 64'h0,                 64'h0,                 0,  0,  0,   0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
